// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared PC vectors, increment and next-PC source encoding
package pc_gen_pkg;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC = 32'h0000_4180;
    localparam int PC_INC = 4;
    typedef enum logic [2:0] {SEQ, BR, RAS, EXC, ERET, HOLD} pc_src_e;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch PC request/response bundle between pipeline control and pc_gen
interface pc_gen_if #(parameter int WIDTH = 32);
    logic stall, br_taken, exc, eret, call, ret, pc_misaligned, ras_hit;
    logic [WIDTH-1:0] br_target, exc_pc, call_link, pc, epc;
    modport master (
        output stall, br_taken, br_target, exc, exc_pc, eret, call, call_link, ret,
        input pc, epc, pc_misaligned, ras_hit
    );
    modport slave (
        input stall, br_taken, br_target, exc, exc_pc, eret, call, call_link, ret,
        output pc, epc, pc_misaligned, ras_hit
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack, push on full overwrites the oldest entry
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] top, wr_addr;
    logic [PW:0] cnt;
    logic pop_eff, wr_en;
    assign empty = cnt == '0;
    assign dout = mem[top];
    assign pop_eff = pop && !empty;
    assign wr_en = push && !flush;
    // pop+push rewrites the current top in place
    assign wr_addr = pop_eff ? top : top + PW'(1);
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push && !pop_eff) begin
            top <= top + PW'(1);
            cnt <= (cnt == (PW+1)'(DEPTH)) ? cnt : cnt + (PW+1)'(1);
        end else if (pop_eff && !push) begin
            top <= top - PW'(1);
            cnt <= cnt - (PW+1)'(1);
        end
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC and EPC registers with prioritised next-PC select; RAS prediction under PC_RAS_EN
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(PC_EXC_VEC),
    parameter int RAS_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    pc_gen_if.slave bus
);
    pc_src_e src;
    logic [WIDTH-1:0] pc_q, epc_q, pc_next, ras_top;
    logic ras_empty, hit_q;
`ifdef PC_RAS_EN
    logic take;
    // decode-side stack ops only when the decode instruction is neither held nor squashed
    assign take = !(bus.stall || bus.exc || bus.eret);
    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.call && take),
        .pop   (bus.ret && take),
        .flush (bus.exc),
        .din   (bus.call_link),
        .dout  (ras_top),
        .empty (ras_empty)
    );
`else
    localparam int unused_depth = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras = ^{bus.call, bus.call_link};
    assign ras_top = '0;
    assign ras_empty = 1'b1;
`endif
    always_comb begin
        src = bus.exc ? EXC :
              bus.eret ? ERET :
              bus.stall ? HOLD :
              bus.br_taken ? BR :
              (bus.ret && !ras_empty) ? RAS : SEQ;
        pc_next = (src == EXC) ? EXC_VEC :
                  (src == ERET) ? epc_q :
                  (src == HOLD) ? pc_q :
                  (src == BR) ? bus.br_target :
                  (src == RAS) ? ras_top : pc_q + WIDTH'(PC_INC);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
            epc_q <= '0;
            hit_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (bus.exc) epc_q <= bus.exc_pc;
            hit_q <= src == RAS;
        end
    end
    assign bus.pc = pc_q;
    assign bus.epc = epc_q;
    assign bus.ras_hit = hit_q;
    assign bus.pc_misaligned = |pc_q[1:0];
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table, RAS corner sequences, random run against a queue-based model
module tb_pc_gen;
    localparam int W = 32;
    localparam int D = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    pc_gen_if #(.WIDTH(W)) bus();
    pc_gen #(.WIDTH(W), .RAS_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic stall, br;
        logic [31:0] tgt;
        logic exc;
        logic [31:0] xpc;
        logic eret, call;
        logic [31:0] link;
        logic ret;
        logic [31:0] e_pc, e_epc;
        logic e_hit;
    } vec_t;
    vec_t tbl[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mpc, mepc;
    logic mhit;
    logic [31:0] mras[$];
    function automatic logic [31:0] sel(logic [31:0] with_ras, logic [31:0] without);
        return RAS_EN ? with_ras : without;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask
    task automatic check_all(string tag, logic [31:0] p, logic [31:0] e, logic h);
        chk({tag, " pc"}, bus.pc, p);
        chk({tag, " epc"}, bus.epc, e);
        chk({tag, " ras_hit"}, 32'(bus.ras_hit), 32'(h));
        chk({tag, " misaligned"}, 32'(bus.pc_misaligned), 32'(p[1:0] != 2'b00));
    endtask
    task automatic drive(vec_t v);
        bus.stall = v.stall;
        bus.br_taken = v.br;
        bus.br_target = v.tgt;
        bus.exc = v.exc;
        bus.exc_pc = v.xpc;
        bus.eret = v.eret;
        bus.call = v.call;
        bus.call_link = v.link;
        bus.ret = v.ret;
    endtask
    task automatic idle();
        vec_t v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(v);
    endtask
    // reference: stack as a queue, newest at the back, at most D entries kept
    task automatic model(vec_t v);
        bit pred;
        logic [31:0] top;
        mhit = 1'b0;
        if (v.exc) begin
            mpc = 32'h4180;
            mepc = v.xpc;
            mras.delete();
        end else if (v.eret) begin
            mpc = mepc;
        end else if (!v.stall) begin
            pred = RAS_EN && v.ret && mras.size() > 0;
            top = pred ? mras[$] : 32'h0;
            if (pred) void'(mras.pop_back());
            if (RAS_EN && v.call) begin
                mras.push_back(v.link);
                if (mras.size() > D) void'(mras.pop_front());
            end
            mpc = v.br ? v.tgt : pred ? top : mpc + 32'd4;
            mhit = pred && !v.br;
        end
    endtask
    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        check_all("reset", 32'h3000, 32'h0, 1'b0);
        rst = 1'b0;
        mpc = 32'h3000;
        mepc = 32'h0;
        mhit = 1'b0;
        mras.delete();
    endtask
    initial begin
        vec_t v;
        idle();
        #1;
        do_reset();
        // stall br tgt exc xpc eret call link ret | pc epc hit
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3010, 0, 0});
        tbl.push_back('{1, 1, 32'h3400, 0, 0, 0, 0, 0, 0, 32'h3010, 0, 0});
        tbl.push_back('{0, 1, 32'h3400, 0, 0, 0, 0, 0, 0, 32'h3400, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 32'h3020, 0, 0, 0, 0, 32'h4180, 32'h3020, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h3020, 32'h3020, 0});
        tbl.push_back('{0, 0, 0, 1, 32'h3030, 1, 0, 0, 0, 32'h4180, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h3030, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3034, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h3100, 0, 32'h3038, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h3200, 0, 32'h303C, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h3200, 32'h3040), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h3100, 32'h3044), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h3104, 32'h3048), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h5000, 0, sel(32'h3108, 32'h304C), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h5100, 0, sel(32'h310C, 32'h3050), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h5200, 0, sel(32'h3110, 32'h3054), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h5300, 0, sel(32'h3114, 32'h3058), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h5400, 0, sel(32'h3118, 32'h305C), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h5400, 32'h3060), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h5300, 32'h3064), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h5200, 32'h3068), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h5100, 32'h306C), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h5104, 32'h3070), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h6000, 0, sel(32'h5108, 32'h3074), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h6100, 1, sel(32'h6000, 32'h3078), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h6100, 32'h307C), 32'h3030, RAS_EN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, sel(32'h6104, 32'h3080), 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h7000, 0, sel(32'h6108, 32'h3084), 32'h3030, 0});
        tbl.push_back('{0, 1, 32'h7700, 0, 0, 0, 0, 0, 1, 32'h7700, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7704, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h7800, 0, 32'h7708, 32'h3030, 0});
        tbl.push_back('{0, 0, 0, 1, 32'h7708, 0, 0, 0, 0, 32'h4180, 32'h7708, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4184, 32'h7708, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 32'h7900, 0, 32'h4184, 32'h7708, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4188, 32'h7708, 0});
        tbl.push_back('{0, 1, 32'h3402, 0, 0, 0, 0, 0, 0, 32'h3402, 32'h7708, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3406, 32'h7708, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h7708, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h7708, 0});
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_hit);
        end
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v.stall = $urandom_range(0, 3) == 0;
            v.br = $urandom_range(0, 6) == 0;
            v.tgt = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            v.exc = $urandom_range(0, 24) == 0;
            v.xpc = $urandom;
            v.eret = $urandom_range(0, 19) == 0;
            v.call = $urandom_range(0, 2) == 0;
            v.link = $urandom & 32'hFFFF_FFFC;
            v.ret = $urandom_range(0, 2) == 0;
            drive(v);
            model(v);
            @(posedge clk);
            #1;
            check_all($sformatf("rand%0d", n), mpc, mepc, mhit);
        end
        idle();
        bus.call = 1'b1;
        bus.call_link = 32'h3600;
        @(posedge clk);
        #1;
        idle();
        bus.br_taken = 1'b1;
        bus.br_target = 32'h3500;
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'h3000, 32'h0, 1'b0);
        idle();
        bus.ret = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 32'h3004, 32'h0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        check_all("post_rst2", 32'h3008, 32'h0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program-counter generator, successor to the single-source PC register. It holds the fetch PC and selects the next PC among sequential increment, decode-stage branch redirect, exception entry, exception return and an optional return-address-stack prediction. It also owns the EPC register. It sits at the head of the IF stage and feeds the instruction memory address and the IF/ID pipeline register.

## Interface
- WIDTH, 32, PC/address width (>= 8)
- RESET_VEC, 32'h0000_3000, PC value on reset
- EXC_VEC, 32'h0000_4180, exception handler entry
- RAS_DEPTH, 4, return-address-stack entries (power of two, >= 2; used only with PC_RAS_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (hazard unit); high = hold
- br_taken  in  1  decode-stage redirect request
- br_target  in  WIDTH  redirect target
- exc  in  1  exception request from a later stage
- exc_pc  in  WIDTH  faulting instruction PC, captured into EPC
- eret  in  1  exception return
- call  in  1  decode sees a link instruction (push)
- call_link  in  WIDTH  return address to push
- ret  in  1  decode sees a return-through-link (pop/predict)
- pc  out  WIDTH  current fetch PC
- epc  out  WIDTH  exception PC register
- pc_misaligned  out  1  combinational, pc[1:0] != 0
- ras_hit  out  1  registered; previous cycle's PC update came from the RAS

## Operation
- Next-PC priority, highest first: exc -> EXC_VEC; eret -> epc; stall -> hold; br_taken -> br_target; ret with RAS non-empty -> RAS top; otherwise pc + 4.
- exc and eret override stall; br_taken, ret, call are ignored while stall = 1. Upstream holds them until accepted.
- exc and eret together: exc wins, eret dropped.
- EPC loads exc_pc on every cycle exc = 1, otherwise holds. eret does not modify EPC.
- pc + 4 wraps modulo 2^WIDTH; no overflow flag.
- br_target, epc and RAS entries are loaded unaltered. Misalignment is only flagged, never corrected.
- RAS is circular with a top pointer and a count saturating at RAS_DEPTH.
  - Push on full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop on empty: no-op, and no prediction is made.
  - call and ret in the same cycle: a pop followed by a push. The top entry is replaced by call_link and count is unchanged. The redirect uses the old top.
  - br_taken in the same cycle as ret: the PC takes br_target, but the pop still occurs.
  - exc clears count to 0. Entries are not zeroed.
- ras_hit = 1 for exactly the cycle after a RAS-sourced PC update, otherwise 0.

## Timing
- Reset values:
  - pc = RESET_VEC
  - epc = 0
  - ras_hit = 0
  - RAS count = 0, top pointer = 0
  - pc_misaligned follows from RESET_VEC
- Assertion of rst takes effect immediately, mid-cycle included. The first update after deassertion happens on the next rising edge.
- All redirects are single-cycle: a request sampled at edge N makes pc equal to the target after edge N.
- No internal pipelining. pc is a register output. There is no combinational path from inputs to pc or epc.

## Configuration
- PC_RAS_EN defined: the RAS is instantiated and call/ret behave as above.
- PC_RAS_EN undefined: no RAS storage; call and ret are ignored; ras_hit is tied 0; the next-PC priority skips the ret term.
- All other behaviour is identical in both builds.

## Structure
- Shared package holds the default vectors (reset 32'h0000_3000, exception 32'h0000_4180) and the PC increment constant 4.
- Shared package also holds a next-PC source enum: SEQ, BR, RAS, EXC, ERET, HOLD.
- One sub-module, pc_ras, holds the stack storage, pointer and count logic, with push/pop/flush/data/empty ports. It is instantiated only under PC_RAS_EN.

## Test plan
- Reset, then 3 free-running cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; epc = 0.
- Three cases with stall = 1 and pc = 0x3010:
  - br_taken with br_target = 0x3400 -> pc holds 0x3010.
  - stall drops with br_taken held -> pc = 0x3400.
  - exc with exc_pc = 0x3020 while stalled -> pc = 0x4180, epc = 0x3020.
- eret after the exception -> pc = 0x3020 next cycle. Same cycle exc + eret -> pc = 0x4180, epc reloads.
- PC_RAS_EN build:
  - Push 0x3100, 0x3200 -> ret gives pc = 0x3200 with ras_hit = 1 next cycle; a second ret gives pc = 0x3100.
  - A third ret on the empty stack -> pc = pc + 4, ras_hit = 0.
- RAS_DEPTH = 4: push 5 entries A..E, then pop 5 times -> targets E, D, C, B, then sequential, since A was overwritten. Simultaneous call/ret replaces the top.
- rst asserted mid-redirect, between clock edges -> pc = 0x3000 immediately; after release, the first edge gives 0x3004; RAS is empty.
